// File: rtl/texture_loader.sv
// Texture loader: fetches the bird, pipe and base images from the SDRAM reader and streams them into the renderer RAMs.
// Define TEXTURE_LOADER_PIPE_TRUNC_EN to fetch only the pipe rows the renderer keeps.
`timescale 1ns/1ps
module texture_loader #(
    parameter int unsigned BIRD_WORDS      = 5250,
    parameter int unsigned PIPE_WORDS      = 40000,
    parameter int unsigned PIPE_KEEP_WORDS = 4000,
    parameter int unsigned BASE_WORDS      = 9600,
    parameter logic [23:0] BIRD_SRC_ADDR   = 24'h000000,
    parameter logic [23:0] PIPE_SRC_ADDR   = 24'h002000,
    parameter logic [23:0] BASE_SRC_ADDR   = 24'h00C000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        seg_req,
    output logic [23:0] seg_addr,
    output logic [15:0] seg_len,
    input  logic        seg_ack,
    input  logic [15:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [15:0] load_data,
    output logic        bird_load_en,
    output logic [12:0] bird_load_addr,
    output logic        pipe_load_en,
    output logic [15:0] pipe_load_addr,
    output logic        base_load_en,
    output logic [13:0] base_load_addr,
    output logic        busy,
    output logic        done,
    output logic        loaded
);

`ifdef TEXTURE_LOADER_PIPE_TRUNC_EN
    localparam bit PIPE_TRUNC = 1'b1;
`else
    localparam bit PIPE_TRUNC = 1'b0;
`endif

    localparam logic [15:0] BIRD_LEN = 16'(BIRD_WORDS);
    localparam logic [15:0] PIPE_LEN = PIPE_TRUNC ? 16'(PIPE_KEEP_WORDS) : 16'(PIPE_WORDS);
    localparam logic [15:0] BASE_LEN = 16'(BASE_WORDS);

    typedef enum logic [2:0] {
        IDLE, REQ_BIRD, XFER_BIRD, REQ_PIPE, XFER_PIPE, REQ_BASE, XFER_BASE, FINISH
    } state_t;

    state_t      state, next_state;
    logic [15:0] count;
    logic [15:0] xfer_len;
    logic        accept;
    logic        last_word;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (start)     next_state = REQ_BIRD;
            REQ_BIRD:  if (seg_ack)   next_state = XFER_BIRD;
            XFER_BIRD: if (last_word) next_state = REQ_PIPE;
            REQ_PIPE:  if (seg_ack)   next_state = XFER_PIPE;
            XFER_PIPE: if (last_word) next_state = REQ_BASE;
            REQ_BASE:  if (seg_ack)   next_state = XFER_BASE;
            XFER_BASE: if (last_word) next_state = FINISH;
            FINISH:    next_state = IDLE;
        endcase
    end

    always_comb begin
        seg_req   = 1'b0;
        seg_addr  = '0;
        seg_len   = '0;
        src_ready = 1'b0;
        xfer_len  = '0;
        case (state)
            REQ_BIRD:  begin seg_req = 1'b1; seg_addr = BIRD_SRC_ADDR; seg_len = BIRD_LEN; end
            REQ_PIPE:  begin seg_req = 1'b1; seg_addr = PIPE_SRC_ADDR; seg_len = PIPE_LEN; end
            REQ_BASE:  begin seg_req = 1'b1; seg_addr = BASE_SRC_ADDR; seg_len = BASE_LEN; end
            XFER_BIRD: begin src_ready = 1'b1; xfer_len = BIRD_LEN; end
            XFER_PIPE: begin src_ready = 1'b1; xfer_len = PIPE_LEN; end
            XFER_BASE: begin src_ready = 1'b1; xfer_len = BASE_LEN; end
            default:   ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign accept    = src_valid && src_ready;
    assign last_word = accept && (count == xfer_len - 16'd1);

    // Word counter restarts on every segment handshake, so each asset writes from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   count <= '0;
        else if (seg_req && seg_ack) count <= '0;
        else if (accept)           count <= count + 16'd1;
    end

    // One-cycle write stage: the enable of the active asset follows each accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_data      <= '0;
            bird_load_en   <= 1'b0;
            pipe_load_en   <= 1'b0;
            base_load_en   <= 1'b0;
            bird_load_addr <= '0;
            pipe_load_addr <= '0;
            base_load_addr <= '0;
        end else begin
            bird_load_en <= accept && (state == XFER_BIRD);
            pipe_load_en <= accept && (state == XFER_PIPE);
            base_load_en <= accept && (state == XFER_BASE);
            if (accept) begin
                load_data      <= src_data;
                bird_load_addr <= count[12:0];
                pipe_load_addr <= count;
                base_load_addr <= count[13:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          loaded <= 1'b0;
        else if (state == IDLE && start)  loaded <= 1'b0;
        else if (state == FINISH)         loaded <= 1'b1;
    end

endmodule
